alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational 16-bit ALU between two requesters.
- The ALU has control bits zx, nx, zy, ny, f, no and flags zr, ng.
- Each requester issues an operation with x, y and a 6-bit control word, using a valid/ready handshake. It later receives out/zr/ng on a per-requester valid/ready response channel.
- Arbitration is round-robin. One operation is in flight at a time. The block sits between requesting sequencers and the ALU instance, and drives the ALU ports directly.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU instance.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_x, req0_y  in  WIDTH  requester 0 operands.
- req0_ctrl  in  6  requester 0 control {zx,nx,zy,ny,f,no}; bit5 = zx, bit0 = no.
- req1_valid, req1_ready, req1_x, req1_y, req1_ctrl  same roles for requester 1.
- rsp0_valid  out  1  result pending for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp1_valid  out  1  result pending for requester 1.
- rsp1_ready  in  1  requester 1 takes the result.
- rsp_out  out  WIDTH  result data, shared by both response channels.
- rsp_zr, rsp_ng  out  1  result flags, shared.
- busy  out  1  high whenever state is not IDLE.
- alu_x, alu_y  out  WIDTH  registered operands to the ALU.
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  out  1  registered ALU control bits.
- alu_out  in  WIDTH  ALU result.
- alu_zr, alu_ng  in  1  ALU flags.

Behaviour:
- Reset (rst_n = 0 at an edge): state goes to IDLE and the priority pointer to requester 0.
- Reset values: req*_ready = 0, rsp*_valid = 0, rsp_out/zr/ng = 0, alu_* = 0, busy = 0.
- Reset mid-operation: an in-flight op in EXEC or RESP is discarded and no response is produced.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE, grant rule:
  - grant = the valid requester; if both are valid, the one named by the priority pointer.
  - reqN_ready = (state == IDLE) && grantN. This is combinational; at most one ready is high.
- IDLE, on handshake (valid && ready):
  - latch x, y, ctrl into alu_x, alu_y, alu_* and record the owner id.
  - go to EXEC.
- IDLE with no valid requester: stay in IDLE; alu_* hold their last values.
- EXEC (1 cycle): capture alu_out, alu_zr, alu_ng into rsp_out/zr/ng, then go to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other rsp valid = 0.
  - On rsp{owner}_ready: go to IDLE and set the priority pointer to the non-owner.
  - Otherwise hold. rsp_out/zr/ng stay stable and all req*_ready stay 0.
- Latency and throughput:
  - Accept at cycle t; rsp_valid is high from t+2.
  - Zero-stall throughput is one op per 3 cycles; the earliest next accept is t+3.
- Requester rules: hold valid and data stable until ready. Dropping valid before ready is allowed and withdraws the request. Data changes while ready = 0 are ignored.
- Responder rules: rsp_ready may be high before rsp_valid. Completion occurs on the first cycle both are high.
- The block does no arithmetic: the result and flags are exactly the ALU's, of width WIDTH.

Test Plan:
- Single op: after reset, req0 x=112, y=310, ctrl=6'b000010 -> req0_ready high at t0; rsp0_valid at t0+2 with rsp_out=422, zr=0, ng=0.
- Flags:
  - req1 x=112, y=310, ctrl=6'b010011 -> rsp_out=16'hFF3A (-198), ng=1, zr=0.
  - then ctrl=6'b101010 -> rsp_out=0, zr=1, ng=0.
- Round-robin: req0 and req1 both valid continuously from reset with rsp*_ready=1 -> grant order 0,1,0,1; accepts exactly 3 cycles apart; no ready ever has both bits high.
- Backpressure: rsp0_ready held low 4 cycles while req1_valid=1 -> rsp0_valid and rsp_out stable for 4 cycles; req1_ready=0 throughout; req1 accepted the cycle after rsp0 completes.
- Reset mid-op: rst_n=0 for 1 cycle during EXEC of a req1 op -> no rsp1_valid ever appears for it; all outputs 0; next simultaneous req0/req1 grants req0 first.
- Withdrawn request: req0_valid pulses 1 cycle while in RESP -> never accepted, no response.

Source files
------------

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; operands and controls to the ALU are registered.
//
//   state  | meaning
//   IDLE   | waiting for a request; grants the valid requester (pointer breaks ties)
//   EXEC   | ALU sees latched operands; result and flags are captured this cycle
//   RESP   | result held on the owner's response channel until it is taken
module alu_rr_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [5:0]       req0_ctrl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [5:0]       req1_ctrl,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp_out,
    output logic             rsp_zr,
    output logic             rsp_ng,

    output logic             busy,

    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic             alu_zx,
    output logic             alu_nx,
    output logic             alu_zy,
    output logic             alu_ny,
    output logic             alu_f,
    output logic             alu_no,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   ptr;      // requester that wins when both are valid
    logic   owner;    // requester whose operation is in flight
    logic   grant0;
    logic   grant1;
    logic   accept0;
    logic   accept1;
    logic   rsp_take;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = ~ptr;
            grant1 = ptr;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign accept0  = req0_valid && req0_ready;
    assign accept1  = req1_valid && req1_ready;
    assign rsp_take = owner ? rsp1_ready : rsp0_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept0 || accept1) state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_RESP;
            S_RESP: if (rsp_take) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs; ready is gated by reset so nothing is accepted on a reset edge
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        busy       = (state != S_IDLE);
        if (rst_n && state == S_IDLE) begin
            req0_ready = grant0;
            req1_ready = grant1;
        end
        if (state == S_RESP) begin
            rsp0_valid = ~owner;
            rsp1_valid = owner;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= 1'b0;
            owner   <= 1'b0;
            alu_x   <= '0;
            alu_y   <= '0;
            alu_zx  <= 1'b0;
            alu_nx  <= 1'b0;
            alu_zy  <= 1'b0;
            alu_ny  <= 1'b0;
            alu_f   <= 1'b0;
            alu_no  <= 1'b0;
            rsp_out <= '0;
            rsp_zr  <= 1'b0;
            rsp_ng  <= 1'b0;
        end else begin
            if (accept0) begin
                owner <= 1'b0;
                alu_x <= req0_x;
                alu_y <= req0_y;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} <= req0_ctrl;
            end else if (accept1) begin
                owner <= 1'b1;
                alu_x <= req1_x;
                alu_y <= req1_y;
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} <= req1_ctrl;
            end
            if (state == S_EXEC) begin
                rsp_out <= alu_out;
                rsp_zr  <= alu_zr;
                rsp_ng  <= alu_ng;
            end
            if (state == S_RESP && rsp_take) begin
                ptr <= ~owner;
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter; includes a behavioural model of the shared ALU.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [5:0]  req0_ctrl, req1_ctrl;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [15:0] rsp_out;
    logic        rsp_zr, rsp_ng, busy;
    logic [15:0] alu_x, alu_y, alu_out;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [15:0] m_x, m_y, m_r;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_ctrl(req1_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_out(rsp_out), .rsp_zr(rsp_zr), .rsp_ng(rsp_ng), .busy(busy),
        .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng)
    );

    // Hack-style ALU attached to the arbiter's ALU ports
    always_comb begin
        m_x = alu_zx ? 16'h0000 : alu_x;
        if (alu_nx) m_x = ~m_x;
        m_y = alu_zy ? 16'h0000 : alu_y;
        if (alu_ny) m_y = ~m_y;
        m_r = alu_f ? (m_x + m_y) : (m_x & m_y);
        if (alu_no) m_r = ~m_r;
        alu_out = m_r;
        alu_zr  = (m_r == 16'h0000);
        alu_ng  = m_r[15];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Drives one operation through and reports latency (accept to rsp_valid) and result.
    task automatic run_op(input bit id, input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] c, output int lat, output logic [15:0] o,
                          output logic z, output logic n);
        int k;
        lat = -1; o = 16'hxxxx; z = 1'bx; n = 1'bx;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        if (id == 1'b0) begin
            req0_x = x; req0_y = y; req0_ctrl = c; req0_valid = 1'b1;
        end else begin
            req1_x = x; req1_y = y; req1_ctrl = c; req1_valid = 1'b1;
        end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 20) begin
            step(); #1; k++;
        end
        if (k >= 20) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        k = 1;
        while (!(id ? rsp1_valid : rsp0_valid) && k < 20) begin
            step(); #1; k++;
        end
        if (k >= 20) return;
        lat = k; o = rsp_out; z = rsp_zr; n = rsp_ng;
        if (id == 1'b0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
        step();
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_status busy=%b rsp0_valid=%b rsp1_valid=%b expected 0 0 0",
                     busy, rsp0_valid, rsp1_valid);
        end
        checks++;
        if (rsp_out !== 16'h0 || rsp_zr !== 1'b0 || rsp_ng !== 1'b0 || alu_x !== 16'h0 ||
            alu_y !== 16'h0 || {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b0) begin
            failures++;
            $display("FAIL reset_data rsp_out=%h zr=%b ng=%b alu_x=%h alu_y=%h expected all 0",
                     rsp_out, rsp_zr, rsp_ng, alu_x, alu_y);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready ready=%b%b expected 00", req1_ready, req0_ready);
        end
        step();
    endtask

    task automatic test_single_op();
        apply_reset();
        req0_x = 16'd112; req0_y = 16'd310; req0_ctrl = 6'b000010; req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_accept ready=%b%b expected 01", req1_ready, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || rsp0_valid !== 1'b0 || alu_x !== 16'd112 || alu_y !== 16'd310 ||
            {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} !== 6'b000010) begin
            failures++;
            $display("FAIL single_exec busy=%b rsp0_valid=%b alu_x=%0d alu_y=%0d expected 1 0 112 310",
                     busy, rsp0_valid, alu_x, alu_y);
        end
        step();
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_out !== 16'd422 ||
            rsp_zr !== 1'b0 || rsp_ng !== 1'b0) begin
            failures++;
            $display("FAIL single_resp rsp0_valid=%b rsp1_valid=%b out=%0d zr=%b ng=%b expected 1 0 422 0 0",
                     rsp0_valid, rsp1_valid, rsp_out, rsp_zr, rsp_ng);
        end
        rsp0_ready = 1'b1;
        step();
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_done busy=%b rsp0_valid=%b expected 0 0", busy, rsp0_valid);
        end
        step();
    endtask

    task automatic test_flags();
        int lat;
        logic [15:0] o;
        logic z, n;
        run_op(1'b1, 16'd112, 16'd310, 6'b010011, lat, o, z, n);
        checks++;
        if (lat !== 2 || o !== 16'hFF3A || z !== 1'b0 || n !== 1'b1) begin
            failures++;
            $display("FAIL flags_neg lat=%0d out=%h zr=%b ng=%b expected 2 ff3a 0 1", lat, o, z, n);
        end
        run_op(1'b1, 16'd112, 16'd310, 6'b101010, lat, o, z, n);
        checks++;
        if (lat !== 2 || o !== 16'h0000 || z !== 1'b1 || n !== 1'b0) begin
            failures++;
            $display("FAIL flags_zero lat=%0d out=%h zr=%b ng=%b expected 2 0000 1 0", lat, o, z, n);
        end
        run_op(1'b0, 16'd20, 16'd4, 6'b000111, lat, o, z, n);
        checks++;
        if (lat !== 2 || o !== 16'hFFF0 || z !== 1'b0 || n !== 1'b1) begin
            failures++;
            $display("FAIL flags_ymx lat=%0d out=%h zr=%b ng=%b expected 2 fff0 0 1", lat, o, z, n);
        end
    endtask

    task automatic test_round_robin();
        int gid[8];
        int gcyc[8];
        int nacc = 0;
        rst_n = 1'b0;
        req0_x = 16'd5; req0_y = 16'd3; req0_ctrl = 6'b000010;
        req1_x = 16'd5; req1_y = 16'd3; req1_ctrl = 6'b010011;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            #1;
            checks++;
            if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
                failures++;
                $display("FAIL rr_onehot cycle=%0d ready=11 expected at most one", cyc);
            end
            if ((req0_ready === 1'b1 || req1_ready === 1'b1) && nacc < 8) begin
                gid[nacc] = (req1_ready === 1'b1) ? 1 : 0;
                gcyc[nacc] = cyc;
                nacc++;
            end
            if (rsp0_valid === 1'b1) begin
                checks++;
                if (rsp_out !== 16'd8) begin
                    failures++;
                    $display("FAIL rr_rsp0 out=%0d expected 8", rsp_out);
                end
            end
            if (rsp1_valid === 1'b1) begin
                checks++;
                if (rsp_out !== 16'd2) begin
                    failures++;
                    $display("FAIL rr_rsp1 out=%0d expected 2", rsp_out);
                end
            end
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (nacc != 4) begin
            failures++;
            $display("FAIL rr_count accepts=%0d expected 4", nacc);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (gid[i] != (i % 2) || gcyc[i] != 3 * i) begin
                    failures++;
                    $display("FAIL rr_order accept=%0d id=%0d cycle=%0d expected id=%0d cycle=%0d",
                             i, gid[i], gcyc[i], i % 2, 3 * i);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        req0_x = 16'd7; req0_y = 16'd9; req0_ctrl = 6'b000010;
        req1_x = 16'd20; req1_y = 16'd4; req1_ctrl = 6'b000111;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_grant ready=%b%b expected 01", req1_ready, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (rsp0_valid !== 1'b1 || rsp_out !== 16'd16 || req1_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cycle=%0d rsp0_valid=%b out=%0d req1_ready=%b expected 1 16 0",
                         i, rsp0_valid, rsp_out, req1_ready);
            end
            step();
        end
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if (rsp0_valid !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_complete rsp0_valid=%b req1_ready=%b expected 1 0", rsp0_valid, req1_ready);
        end
        step();
        rsp0_ready = 1'b0;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || rsp0_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_next req1_ready=%b rsp0_valid=%b expected 1 0", req1_ready, rsp0_valid);
        end
        step();
        req1_valid = 1'b0;
        step();
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_out !== 16'hFFF0 || rsp_ng !== 1'b1) begin
            failures++;
            $display("FAIL bp_req1_rsp rsp1_valid=%b out=%h ng=%b expected 1 fff0 1",
                     rsp1_valid, rsp_out, rsp_ng);
        end
        step();
        rsp1_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        int seen = 0;
        apply_reset();
        req1_x = 16'd1; req1_y = 16'd1; req1_ctrl = 6'b000010; req1_valid = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_accept req1_ready=%b expected 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_out !== 16'h0 ||
            alu_x !== 16'h0 || alu_y !== 16'h0 || alu_f !== 1'b0 ||
            req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_clear busy=%b rsp_valid=%b%b out=%h alu_x=%h alu_f=%b expected all 0",
                     busy, rsp1_valid, rsp0_valid, rsp_out, alu_x, alu_f);
        end
        for (int i = 0; i < 5; i++) begin
            if (rsp1_valid === 1'b1) seen++;
            step(); #1;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midrst_no_rsp rsp1_valid_cycles=%0d expected 0", seen);
        end
        rsp1_ready = 1'b0;
        req0_x = 16'd2; req0_y = 16'd2; req0_ctrl = 6'b000010;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #0;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ptr ready=%b%b expected 01", req1_ready, req0_ready);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_withdrawn();
        int bad = 0;
        apply_reset();
        req1_x = 16'd3; req1_y = 16'd4; req1_ctrl = 6'b000010; req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        step();
        #1;
        checks++;
        if (rsp1_valid !== 1'b1 || rsp_out !== 16'd7) begin
            failures++;
            $display("FAIL wd_resp rsp1_valid=%b out=%0d expected 1 7", rsp1_valid, rsp_out);
        end
        req0_x = 16'd9; req0_y = 16'd9; req0_ctrl = 6'b000010; req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL wd_ready_in_resp req0_ready=%b expected 0", req0_ready);
        end
        step();
        req0_valid = 1'b0;
        rsp1_ready = 1'b1;
        step();
        rsp1_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (req0_ready === 1'b1 || rsp0_valid === 1'b1 || busy === 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wd_never_accepted bad_cycles=%0d expected 0", bad);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req0_ctrl = '0;
        req1_x = '0; req1_y = '0; req1_ctrl = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single_op();
        test_flags();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        test_withdrawn();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
